// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog: run request, ratio load handshake and divided-clock outputs.
interface clk_div_prog_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic [DIV_W-1:0] div_cur;
  logic             err;
  logic             clk_out;
  logic             clk_en_out;

  modport master (
    output en, div_val, div_load,
    input  div_ack, div_cur, err, clk_out, clk_en_out
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ack, div_cur, err, clk_out, clk_en_out
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with boundary-aligned ratio changes and glitch-free stop.
// Optional macro CLK_DIV_PROG_ODD_DUTY50_EN adds a falling-edge flop for 50% duty on odd ratios.
module clk_div_prog #(
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 2
) (
  input  logic         clk_in_i,
  input  logic         resetn_i,
  clk_div_prog_if.slave bus
);

  typedef enum logic [1:0] {ST_STOPPED, ST_RUN, ST_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             applied_q, applied_d;
  logic             ack_q, ack_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;

  logic             running;
  logic             terminal;
  logic             load_ok;
  logic             load_bad;
  logic [DIV_W-1:0] hi;

  assign running  = (state_q != ST_STOPPED);
  assign terminal = (cnt_q == div_cur_q - DIV_W'(1));
  assign load_ok  = bus.div_load && (bus.div_val != '0);
  assign load_bad = bus.div_load && (bus.div_val == '0);

`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
  assign hi = div_cur_q >> 1;
`else
  assign hi = div_cur_q - (div_cur_q >> 1);
`endif

  always_ff @(posedge clk_in_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_STOPPED;
      cnt_q      <= '0;
      div_cur_q  <= DIV_W'(DIV_INIT);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      applied_q  <= 1'b0;
      ack_q      <= 1'b0;
      clk_out_q  <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      applied_q  <= applied_d;
      ack_q      <= ack_d;
      clk_out_q  <= clk_out_d;
      clk_en_q   <= clk_en_d;
    end
  end

  // Outputs are a registered decode of the counter, so they trail cnt_q by one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    err_d      = err_q;
    applied_d  = 1'b0;
    ack_d      = applied_q;
    clk_out_d  = running && (div_cur_q != DIV_W'(1)) && (cnt_q < hi);
    clk_en_d   = running && (cnt_q == '0);

    if (load_bad) err_d = 1'b1;
    if (load_ok)  err_d = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        cnt_d = '0;
        if (load_ok) begin
          div_cur_d = bus.div_val;
          ack_d     = 1'b1;
        end
        if (bus.en) state_d = ST_RUN;
      end
      default: begin
        if (load_ok) begin
          pend_d     = 1'b1;
          pend_val_d = bus.div_val;
        end
        if (terminal) begin
          cnt_d = '0;
          if (pend_q || load_ok) begin
            div_cur_d = load_ok ? bus.div_val : pend_val_q;
            pend_d    = 1'b0;
            applied_d = 1'b1;
          end
          // Re-asserted EN on the terminal edge keeps the block running.
          state_d = bus.en ? ST_RUN : ST_STOPPED;
        end else begin
          cnt_d   = cnt_q + DIV_W'(1);
          state_d = bus.en ? ST_RUN : ST_DRAIN;
        end
      end
    endcase
  end

`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
  logic odd_q;
  logic neg_q;

  always_ff @(posedge clk_in_i or negedge resetn_i) begin
    if (!resetn_i) odd_q <= 1'b0;
    else           odd_q <= div_cur_q[0] && (div_cur_q != DIV_W'(1));
  end

  // Half-cycle delayed copy of the high term stretches odd-ratio high time by half a cycle.
  always_ff @(negedge clk_in_i or negedge resetn_i) begin
    if (!resetn_i) neg_q <= 1'b0;
    else           neg_q <= clk_out_q && odd_q;
  end

  assign bus.clk_out = clk_out_q | neg_q;
`else
  assign bus.clk_out = clk_out_q;
`endif

  assign bus.clk_en_out = clk_en_q;
  assign bus.div_ack    = ack_q;
  assign bus.div_cur    = div_cur_q;
  assign bus.err        = err_q;

endmodule
